// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by the I2C target and the I2C controller.
//   i2c_state_t   - target protocol state
//   I2C_ACK/NACK  - SDA level for the ninth-clock acknowledge bit
//   I2C_RW_READ   - value of the R/W bit that requests a read
//   addr_match()  - compares an address byte {addr[6:0], rw} with a 7-bit address
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_DATA  = 3'd3,
    WR_ACK   = 3'd4,
    RD_DATA  = 3'd5,
    RD_ACK   = 3'd6,
    IGNORE   = 3'd7
  } i2c_state_t;

  localparam logic I2C_ACK     = 1'b0;
  localparam logic I2C_NACK    = 1'b1;
  localparam logic I2C_RW_READ = 1'b1;

  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] addr);
    return (addr_byte[7:1] == addr);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: brings SCL/SDA into the clk domain and derives bus events.
// Ports:
//   clk, rst                 system clock, async active-high reset
//   scl_in, sda_in           raw bus levels
//   scl_s, sda_s             synchronized levels
//   scl_rise, scl_fall       one-clk pulses on synchronized SCL edges
//   start_det, stop_det      one-clk pulses: SDA falls / rises while SCL is high
// SYNC_STAGES must be at least 2.
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_q;
  logic                   sda_q;

  // Flops reset to the idle-bus level (both lines high) so that leaving
  // reset on a quiet bus produces no spurious START or edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_q    <= scl_s;
      sda_q    <= sda_s;
    end
  end

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  assign start_det =  scl_s & sda_q & ~sda_s;
  assign stop_det  =  scl_s & ~sda_q & sda_s;

endmodule

// File: rtl/i2c_target.sv
// i2c_target: I2C responder with a 7-bit address, no clock stretching.
// Ports:
//   clk, rst       system clock (>= 8x SCL), async active-high reset
//   scl_in, sda_in bus levels
//   sda_oe         1 = pull SDA low, 0 = release
//   rx_data/valid  byte written by the controller, valid for one clk
//   rx_ready       local side accepts the byte; 0 makes us NACK it
//   tx_data/req    tx_req pulses for one clk; tx_data is sampled on that clk
//   selected       address ACKed, until STOP or repeated START
//   busy           between START and STOP
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | bus free or unknown, waiting for START
// ADDR     | shifting in {addr, rw}
// ADDR_ACK | holding SDA low for the address ACK
// WR_DATA  | shifting in a write byte
// WR_ACK   | ACK (rx_ready=1) or NACK slot of a write byte
// RD_DATA  | shifting out a read byte
// RD_ACK   | controller ACK/NACK slot of a read byte
// IGNORE   | not addressed or read ended with NACK; bus released
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TGT_ADDR    = 7'h54,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       selected,
  output logic       busy
);

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .scl_s     (scl_s),
    .sda_s     (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  i2c_state_t state, state_n;
  logic [7:0] shift, shift_n;
  logic [3:0] cnt, cnt_n;
  logic       rw, rw_n;
  logic       ack_pend, ack_pend_n;   // write: ACK the byte; read: controller ACKed
  logic       sda_oe_n, selected_n, busy_n, rx_valid_n, tx_req_n;
  logic [7:0] rx_data_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= 8'h00;
      cnt      <= 4'd0;
      rw       <= 1'b0;
      ack_pend <= 1'b0;
      sda_oe   <= 1'b0;
      selected <= 1'b0;
      busy     <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
    end else begin
      state    <= state_n;
      shift    <= shift_n;
      cnt      <= cnt_n;
      rw       <= rw_n;
      ack_pend <= ack_pend_n;
      sda_oe   <= sda_oe_n;
      selected <= selected_n;
      busy     <= busy_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
    end
  end

  always_comb begin
    state_n    = state;
    shift_n    = shift;
    cnt_n      = cnt;
    rw_n       = rw;
    ack_pend_n = ack_pend;
    sda_oe_n   = sda_oe;
    selected_n = selected;
    busy_n     = busy;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;

    if (start_det) begin
      // any partially shifted bit in this clk is dropped
      state_n    = ADDR;
      busy_n     = 1'b1;
      selected_n = 1'b0;
      cnt_n      = 4'd0;
      sda_oe_n   = 1'b0;
    end else if (stop_det) begin
      state_n    = IDLE;
      busy_n     = 1'b0;
      selected_n = 1'b0;
      sda_oe_n   = 1'b0;
    end else if (tx_req && !scl_s) begin
      // read byte load happens one clk after the SCL fall that requested it,
      // still inside the SCL low phase
      shift_n  = tx_data;
      sda_oe_n = ~tx_data[7];
    end else begin
      unique case (state)
        IDLE, IGNORE: begin
          sda_oe_n = 1'b0;
        end

        ADDR: begin
          if (scl_rise && cnt < 4'd8) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            if (addr_match(shift, TGT_ADDR)) begin
              sda_oe_n   = 1'b1;
              rw_n       = shift[0];
              selected_n = 1'b1;
              state_n    = ADDR_ACK;
            end else begin
              state_n = IGNORE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = 4'd0;
            if (rw == I2C_RW_READ) begin
              // SDA stays low until the byte loads on the next clk
              tx_req_n = 1'b1;
              state_n  = RD_DATA;
            end else begin
              sda_oe_n = 1'b0;
              state_n  = WR_DATA;
            end
          end
        end

        WR_DATA: begin
          if (scl_rise && cnt < 4'd8) begin
            shift_n = {shift[6:0], sda_s};
            cnt_n   = cnt + 4'd1;
            if (cnt == 4'd7) begin
              rx_data_n  = {shift[6:0], sda_s};
              rx_valid_n = rx_ready;
              ack_pend_n = rx_ready;
            end
          end else if (scl_fall && cnt == 4'd8) begin
            sda_oe_n = ack_pend;
            state_n  = WR_ACK;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            sda_oe_n = 1'b0;
            cnt_n    = 4'd0;
            state_n  = WR_DATA;
          end
        end

        RD_DATA: begin
          if (scl_fall) begin
            if (cnt == 4'd7) begin
              sda_oe_n   = 1'b0;
              ack_pend_n = 1'b0;
              state_n    = RD_ACK;
            end else begin
              shift_n  = {shift[6:0], 1'b0};
              sda_oe_n = ~shift[6];
              cnt_n    = cnt + 4'd1;
            end
          end
        end

        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_NACK) state_n = IGNORE;
            else                   ack_pend_n = 1'b1;
          end else if (scl_fall && ack_pend) begin
            tx_req_n   = 1'b1;
            ack_pend_n = 1'b0;
            cnt_n      = 4'd0;
            state_n    = RD_DATA;
          end
        end

        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) for the bus end opposite our I2C controller.
- Samples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it.
- On write, delivers received bytes to local logic; on read, shifts out bytes supplied by local logic.
- Drives SDA open-drain only (pull low or release); never drives SCL (no clock stretching).

Parameters:
- TGT_ADDR, 7'h54, 7-bit bus address this target answers to.
- SYNC_STAGES, 2, synchronizer flops on scl_in/sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must be at least 8x SCL frequency.
- rst  input  1  reset, asynchronous, active-high.
- scl_in  input  1  bus SCL level.
- sda_in  input  1  bus SDA level, read back from the pulled-up wire.
- sda_oe  output  1  1 = pull SDA low, 0 = release.
- rx_data  output  8  last byte written by the controller.
- rx_valid  output  1  one-clk pulse when rx_data updates.
- rx_ready  input  1  local side can accept a byte; sampled at byte end; 0 -> NACK.
- tx_data  input  8  byte to send on read; sampled on the clk where tx_req=1.
- tx_req  output  1  one-clk pulse requesting the next read byte.
- selected  output  1  high from address ACK until STOP or repeated START.
- busy  output  1  high between START and STOP.

Behaviour:
- Reset: all outputs 0, state IDLE, shift register 0, bit counter 0. An async reset mid-transfer releases SDA immediately; the block then waits for the next START.
- Sync: scl_s/sda_s come from SYNC_STAGES flops.
- Edge detection: scl_rise/scl_fall are one-clk pulses from the previous sampled value.
- START: sda_s falls while scl_s=1. STOP: sda_s rises while scl_s=1. Both are evaluated before bit logic and take priority in any state.
- START (including repeated START), from any state: go to ADDR, busy=1, selected=0, bit count=0, sda_oe=0.
- STOP, from any state: go to IDLE, busy=0, selected=0, sda_oe=0.
- Bit order: MSB first. Bits are sampled on scl_rise; SDA is changed only on scl_fall.
- FSM transitions:
  - IDLE -> ADDR on START.
  - ADDR: shift 8 bits; byte = {addr[6:0], rw}.
    - Match: on the scl_fall after bit 8, sda_oe=1 and go to ADDR_ACK.
    - Mismatch: go to IGNORE, SDA untouched.
  - ADDR_ACK: set selected=1. On the next scl_fall, go to WR_DATA with sda_oe=0 if rw=0. If rw=1, pulse tx_req, load tx_data, drive bit 7 (sda_oe=~bit) and go to RD_DATA.
  - WR_DATA: shift 8 bits. On the clk after the 8th scl_rise, rx_data=byte and rx_valid=1 if rx_ready=1. On the following scl_fall, sda_oe=rx_ready and go to WR_ACK.
  - WR_ACK: on the next scl_fall, sda_oe=0 and go to WR_DATA.
  - RD_DATA: on each scl_fall, present the next bit. After 8 bits, release SDA on scl_fall and go to RD_ACK.
  - RD_ACK: sample the controller ACK on scl_rise.
    - sda_s=0 (ACK): on the next scl_fall, pulse tx_req, load tx_data, drive bit 7, go to RD_DATA.
    - sda_s=1 (NACK): go to IGNORE with SDA released.
  - IGNORE: hold sda_oe=0 until START or STOP.
- Latency: rx_valid is asserted SYNC_STAGES+1 clks after the bus SCL rising edge of bit 0.
- Simultaneous events: START/STOP detected on the same clk as an scl edge take precedence; that bit is discarded.
- sda_oe must never change while scl_s=1, except on STOP/START/reset release.
- Timing limit: no glitch filtering beyond the synchronizers; SCL high/low phases shorter than 4 clk are out of spec.

Decomposition:
- Shared package i2c_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE).
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_RW_READ=1'b1.
  - Shared with the controller.
- Sub-module i2c_bus_sync: synchronizers plus scl_rise, scl_fall, start_det, stop_det pulses. Reusable by the controller for arbitration readback.

Test Plan:
- Write: START, byte 8'hA8, data 8'h4D, 8'hCA, STOP, rx_ready=1 -> ACK on the address and on both data bytes; rx_valid pulses twice with 8'h4D then 8'hCA; busy falls after STOP.
- Address mismatch: START, 8'hA6, data 8'h4D, STOP -> sda_oe stays 0 throughout, no rx_valid, selected stays 0.
- Read: START, 8'hA9, tx_data=8'hCA, controller ACKs byte 1 and NACKs byte 2 (tx_data=8'h35) -> bus carries 8'hCA then 8'h35; tx_req pulses twice; IGNORE until STOP.
- Write with rx_ready=0 on the second byte -> first byte ACKed; second byte NACKed (SDA high at the 9th clock); rx_valid only once.
- Repeated START: write 8'hA8/8'h12, then repeated START with 8'hA9 -> rx 8'h12, then read path entered without STOP; selected re-asserts after the new address ACK.
- Reset mid read, with sda_oe=1 during a 0 bit -> sda_oe=0 within the same clk; a new START with 8'hA8 is ACKed normally.
